// File: rtl/bramac_pkg.sv
// Shared definitions for the BrAMAC instruction sequencer and its bench.
package bramac_pkg;

    // Instruction word layout
    localparam int unsigned INST_W     = 40;
    localparam int unsigned PREC_LSB   = 0;
    localparam int unsigned PREC_W     = 2;
    localparam int unsigned INTYPE_BIT = 2;
    localparam int unsigned RESET_BIT  = 3;
    localparam int unsigned START_BIT  = 4;
    localparam int unsigned COPY_BIT   = 5;
    localparam int unsigned DONE_BIT   = 6;
    localparam int unsigned ROW1_LSB   = 7;
    localparam int unsigned ROW2_LSB   = 14;
    localparam int unsigned COL_LSB    = 21;
    localparam int unsigned IN1_LSB    = 23;
    localparam int unsigned IN2_LSB    = 31;
    localparam int unsigned ROW_W      = 7;
    localparam int unsigned COL_W      = 2;
    localparam int unsigned IN_W       = 8;
    localparam int unsigned OP_W       = 2 * IN_W + COL_W + 2 * ROW_W;

    // Precision codes
    localparam logic [1:0] PREC_ILLEGAL = 2'b00;
    localparam logic [1:0] PREC_2B      = 2'b01;
    localparam logic [1:0] PREC_4B      = 2'b10;
    localparam logic [1:0] PREC_8B      = 2'b11;

    typedef enum logic [3:0] {
        StIdle, StWait, StRst, StStart, StInit, StCopy, StCalc, StAcc, StDone1, StDone2, StAbort
    } seq_state_e;

    // One operand pair as held in the FIFO
    typedef struct packed {
        logic [IN_W-1:0]  in_2;
        logic [IN_W-1:0]  in_1;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row_2;
        logic [ROW_W-1:0] row_1;
    } op_entry_t;

    // Operand bit width p for a precision code; 0 for the illegal code
    function automatic logic [3:0] prec_to_p(input logic [1:0] prec);
        case (prec)
            PREC_2B: return 4'd2;
            PREC_4B: return 4'd4;
            PREC_8B: return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/bramac_op_fifo.sv
// Synchronous operand FIFO; push and pop may coincide even when full.
module bramac_op_fifo
    import bramac_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = OP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/bramac_inst_seq.sv
// Replays the fsm_1da cycle schedule as a per-cycle BrAMAC instruction word.
module bramac_inst_seq
    import bramac_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_bram,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [1:0]        job_prec,
    input  logic              job_intype,
    input  logic [CNT_W-1:0]  job_npairs,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [6:0]        op_row_1,
    input  logic [6:0]        op_row_2,
    input  logic [1:0]        op_col,
    input  logic [7:0]        op_in_1,
    input  logic [7:0]        op_in_2,
    output logic              comp_en,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              result_valid,
    output logic              err_underrun,
    output logic              err_prec
);

    seq_state_e                state_q, state_d;
    logic [1:0]                prec_q;
    logic                      intype_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [3:0]                calc_q, calc_d;
    logic [ROW_W-1:0]          hold_row1_q, hold_row2_q;
    logic [COL_W-1:0]          hold_col_q;
    logic                      err_underrun_q, err_prec_q;
    logic                      accept, pop, underrun, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    op_entry_t                 head, push_entry;
    logic [31:0]               need, have;

    assign accept     = job_valid & job_ready;
    assign job_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    // A pop in the same cycle frees the slot the push lands in
    assign op_ready   = ~fifo_full | pop;
    assign push_entry = {op_in_2, op_in_1, op_col, op_row_2, op_row_1};
    assign need       = (32'(cnt_q) < FIFO_DEPTH) ? 32'(cnt_q) : FIFO_DEPTH;
    assign have       = 32'(fifo_count);
    assign err_underrun = err_underrun_q | underrun;
    assign err_prec     = err_prec_q;

    bramac_op_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OP_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset_bram),
        .push  (op_valid & op_ready),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register
    always_ff @(posedge clk or posedge reset_bram) begin
        if (reset_bram) state_q <= StIdle;
        else            state_q <= state_d;
    end

    // Next state, pair/calc counters and pop decisions
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        calc_d   = calc_q;
        pop      = 1'b0;
        underrun = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (job_valid) begin
                    cnt_d = job_npairs;
                    if (job_npairs != '0 && job_prec != PREC_ILLEGAL) state_d = StWait;
                end
            end
            StWait:  if (have >= need) state_d = StRst;
            StRst:   state_d = StStart;
            StStart: state_d = StInit;
            StInit: begin
                if (fifo_empty) begin
                    underrun = 1'b1;
                    state_d  = StAbort;
                end else begin
                    pop     = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = StCopy;
                end
            end
            StCopy: begin
                calc_d  = '0;
                state_d = StCalc;
            end
            StCalc: begin
                if (calc_q == prec_to_p(prec_q) + 4'd1) state_d = StAcc;
                else                                    calc_d  = calc_q + 4'd1;
            end
            StAcc: begin
                if (cnt_q == '0) begin
                    state_d = StDone1;
                end else if (fifo_empty) begin
                    underrun = 1'b1;
                    state_d  = StAbort;
                end else begin
                    pop     = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = StCopy;
                end
            end
            StDone1: state_d = StDone2;
            StDone2: state_d = StIdle;
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Job registers, counters, address hold and error flags
    always_ff @(posedge clk or posedge reset_bram) begin
        if (reset_bram) begin
            prec_q         <= '0;
            intype_q       <= 1'b0;
            cnt_q          <= '0;
            calc_q         <= '0;
            hold_row1_q    <= '0;
            hold_row2_q    <= '0;
            hold_col_q     <= '0;
            err_underrun_q <= 1'b0;
            err_prec_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            calc_q     <= calc_d;
            err_prec_q <= accept && (job_prec == PREC_ILLEGAL);
            if (accept) begin
                prec_q         <= job_prec;
                intype_q       <= job_intype;
                err_underrun_q <= 1'b0;
            end else if (underrun) begin
                err_underrun_q <= 1'b1;
            end
            if (pop) begin
                hold_row1_q <= head.row_1;
                hold_row2_q <= head.row_2;
                hold_col_q  <= head.col;
            end
        end
    end

    // Instruction word and compute-mode outputs
    always_comb begin
        inst         = '0;
        result_valid = 1'b0;
        comp_en      = (state_q != StIdle) && (state_q != StWait);
        if (busy) begin
            inst[PREC_LSB +: PREC_W] = prec_q;
            inst[INTYPE_BIT]         = intype_q;
        end
        unique case (state_q)
            StRst:   inst[RESET_BIT] = 1'b1;
            StStart: inst[START_BIT] = 1'b1;
            StInit: begin
                if (!fifo_empty) begin
                    inst[IN1_LSB +: IN_W] = head.in_1;
                    inst[IN2_LSB +: IN_W] = head.in_2;
                end
            end
            StCopy: begin
                inst[COPY_BIT]            = 1'b1;
                inst[ROW1_LSB +: ROW_W]   = hold_row1_q;
                inst[ROW2_LSB +: ROW_W]   = hold_row2_q;
                inst[COL_LSB +: COL_W]    = hold_col_q;
            end
            StAcc: begin
                if (cnt_q == '0) begin
                    inst[DONE_BIT] = 1'b1;
                end else if (!fifo_empty) begin
                    inst[IN1_LSB +: IN_W] = head.in_1;
                    inst[IN2_LSB +: IN_W] = head.in_2;
                end
            end
            StDone2: begin
                inst[RESET_BIT] = 1'b1;
                result_valid    = 1'b1;
            end
            StAbort: inst[RESET_BIT] = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bramac_inst_seq.sv
// Self-checking bench for bramac_inst_seq against a cycle-schedule model.
module tb_bramac_inst_seq;

    logic        clk = 1'b0;
    logic        reset_bram;
    logic        job_valid, job_ready, job_intype;
    logic [1:0]  job_prec;
    logic [7:0]  job_npairs;
    logic        op_valid, op_ready;
    logic [6:0]  op_row_1, op_row_2;
    logic [1:0]  op_col;
    logic [7:0]  op_in_1, op_in_2;
    logic        comp_en, busy, result_valid, err_underrun, err_prec;
    logic [39:0] inst;

    int vectors = 0;
    int miscompares = 0;

    // Job pair storage, indexed in job order
    logic [6:0] pr1 [16];
    logic [6:0] pr2 [16];
    logic [1:0] pcol[16];
    logic [7:0] pa  [16];
    logic [7:0] pb  [16];
    int         push_q[$];

    // Model parameters of the job under test
    logic [1:0] m_prec;
    logic       m_int;
    int         m_n, m_avail, m_len;

    typedef struct packed {
        logic [39:0] inst;
        logic        comp_en;
        logic        busy;
        logic        rv;
        logic        uerr;
    } exp_t;

    bramac_inst_seq #(.CNT_W(8), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset_bram   (reset_bram),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_prec     (job_prec),
        .job_intype   (job_intype),
        .job_npairs   (job_npairs),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_row_1     (op_row_1),
        .op_row_2     (op_row_2),
        .op_col       (op_col),
        .op_in_1      (op_in_1),
        .op_in_2      (op_in_2),
        .comp_en      (comp_en),
        .inst         (inst),
        .busy         (busy),
        .result_valid (result_valid),
        .err_underrun (err_underrun),
        .err_prec     (err_prec)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    // Expected outputs k cycles after job acceptance, from the schedule rules
    function automatic exp_t model(int k);
        exp_t e;
        int fail_k, end_k, j, i, o;
        e = '0;
        fail_k = (m_avail < m_n) ? 4 + m_avail * m_len : -1;
        end_k  = (fail_k >= 0) ? fail_k + 1 : 6 + m_n * m_len;
        if (k < 1 || k > end_k) begin
            e.uerr = (fail_k >= 0 && k > end_k);
            return e;
        end
        e.busy      = 1'b1;
        e.inst[1:0] = m_prec;
        e.inst[2]   = m_int;
        e.comp_en   = (k >= 2);
        if (fail_k >= 0 && k >= fail_k) begin
            e.uerr    = 1'b1;
            e.inst[3] = (k == end_k);
            return e;
        end
        if (k == 2) e.inst[3] = 1'b1;
        else if (k == 3) e.inst[4] = 1'b1;
        else if (k == 4) begin
            e.inst[30:23] = pa[0];
            e.inst[38:31] = pb[0];
        end else if (k == end_k) begin
            e.inst[3] = 1'b1;
            e.rv      = 1'b1;
        end else if (k < 5 + m_n * m_len) begin
            j = k - 5;
            i = j / m_len;
            o = j % m_len;
            if (o == 0) begin
                e.inst[5]     = 1'b1;
                e.inst[13:7]  = pr1[i];
                e.inst[20:14] = pr2[i];
                e.inst[22:21] = pcol[i];
            end else if (o == m_len - 1) begin
                if (i == m_n - 1) e.inst[6] = 1'b1;
                else begin
                    e.inst[30:23] = pa[i+1];
                    e.inst[38:31] = pb[i+1];
                end
            end
        end
        return e;
    endfunction

    // Present the queue head on the operand port; dequeue once it is accepted
    task automatic step_push();
        if (push_q.size() > 0) begin
            op_valid = 1'b1;
            op_row_1 = pr1[push_q[0]];
            op_row_2 = pr2[push_q[0]];
            op_col   = pcol[push_q[0]];
            op_in_1  = pa[push_q[0]];
            op_in_2  = pb[push_q[0]];
            if (op_ready) void'(push_q.pop_front());
        end else begin
            op_valid = 1'b0;
        end
    endtask

    task automatic gen_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            pr1[i]  = 7'($urandom);
            pr2[i]  = 7'($urandom);
            pcol[i] = 2'($urandom);
            pa[i]   = 8'($urandom);
            pb[i]   = 8'($urandom);
        end
    endtask

    // Prefill, accept a job, then compare every cycle against the model
    task automatic run_job(input logic [1:0] prec, input logic intype, input int n,
                           input int prefill, input int avail, input bit strm,
                           input int stop_k);
        exp_t e;
        int   limit, guard;
        m_prec  = prec;
        m_int   = intype;
        m_n     = n;
        m_avail = avail;
        m_len   = ((prec == 2'd1) ? 2 : (prec == 2'd2) ? 4 : 8) + 4;
        push_q.delete();
        for (int i = 0; i < prefill; i++) push_q.push_back(i);
        guard = 0;
        while (push_q.size() > 0 && guard < 40) begin
            @(negedge clk);
            step_push();
            guard++;
        end
        @(negedge clk);
        vectors++;
        if (push_q.size() != 0) begin
            miscompares++;
            $display("FAIL prefill left=%0d required=0", push_q.size());
        end
        for (int i = prefill; i < avail; i++) push_q.push_back(i);
        step_push();
        vectors++;
        if (job_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL job_ready_at_accept got=%b want=1", job_ready);
        end
        job_valid  = 1'b1;
        job_prec   = prec;
        job_intype = intype;
        job_npairs = 8'(n);
        limit = (avail < n) ? 7 + avail * m_len : 8 + n * m_len;
        if (stop_k > 0) limit = stop_k;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (k == 1) job_valid = 1'b0;
            e = model(k);
            vectors += 7;
            if (inst !== e.inst) begin
                miscompares++;
                $display("FAIL inst k=%0d got=%h want=%h", k, inst, e.inst);
            end
            if (comp_en !== e.comp_en) begin
                miscompares++;
                $display("FAIL comp_en k=%0d got=%b want=%b", k, comp_en, e.comp_en);
            end
            if (busy !== e.busy) begin
                miscompares++;
                $display("FAIL busy k=%0d got=%b want=%b", k, busy, e.busy);
            end
            if (job_ready !== !e.busy) begin
                miscompares++;
                $display("FAIL job_ready k=%0d got=%b want=%b", k, job_ready, !e.busy);
            end
            if (result_valid !== e.rv) begin
                miscompares++;
                $display("FAIL result_valid k=%0d got=%b want=%b", k, result_valid, e.rv);
            end
            if (err_underrun !== e.uerr) begin
                miscompares++;
                $display("FAIL err_underrun k=%0d got=%b want=%b", k, err_underrun, e.uerr);
            end
            if (err_prec !== 1'b0) begin
                miscompares++;
                $display("FAIL err_prec k=%0d got=%b want=0", k, err_prec);
            end
            if (strm && (k == 4 || k == 5)) begin
                vectors++;
                if (op_ready !== (k == 4)) begin
                    miscompares++;
                    $display("FAIL op_ready_full k=%0d got=%b want=%b", k, op_ready, k == 4);
                end
            end
            step_push();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors += 8;
        if (job_ready !== 1'b1)    begin miscompares++; $display("FAIL rst_job_ready got=%b want=1", job_ready); end
        if (op_ready !== 1'b1)     begin miscompares++; $display("FAIL rst_op_ready got=%b want=1", op_ready); end
        if (inst !== 40'h0)        begin miscompares++; $display("FAIL rst_inst got=%h want=0", inst); end
        if (comp_en !== 1'b0)      begin miscompares++; $display("FAIL rst_comp_en got=%b want=0", comp_en); end
        if (busy !== 1'b0)         begin miscompares++; $display("FAIL rst_busy got=%b want=0", busy); end
        if (result_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rv got=%b want=0", result_valid); end
        if (err_underrun !== 1'b0) begin miscompares++; $display("FAIL rst_uerr got=%b want=0", err_underrun); end
        if (err_prec !== 1'b0)     begin miscompares++; $display("FAIL rst_eprec got=%b want=0", err_prec); end
        @(negedge clk);
        reset_bram = 1'b0;
    endtask

    task automatic test_prec4_signed();
        gen_pairs(2);
        pa[0] = 8'h35; pb[0] = 8'h7A;
        pa[1] = 8'h81; pb[1] = 8'h02;
        run_job(2'b10, 1'b1, 2, 2, 2, 1'b0, 0);
    endtask

    task automatic test_prec2_single();
        gen_pairs(1);
        run_job(2'b01, 1'($urandom), 1, 1, 1, 1'b0, 0);
    endtask

    task automatic test_random_jobs();
        int n;
        for (int j = 0; j < 5; j++) begin
            n = $urandom_range(1, 4);
            gen_pairs(n);
            run_job(2'($urandom_range(1, 3)), 1'($urandom), n, n, n, 1'b0, 0);
        end
    endtask

    task automatic test_back_to_back();
        gen_pairs(6);
        run_job(2'b10, 1'($urandom), 6, 4, 6, 1'b1, 0);
    endtask

    task automatic test_underrun();
        gen_pairs(5);
        run_job(2'b11, 1'($urandom), 5, 4, 4, 1'b0, 0);
    endtask

    task automatic test_bad_job(input logic [1:0] prec, input logic [7:0] n, input logic want_ep);
        @(negedge clk);
        job_valid  = 1'b1;
        job_prec   = prec;
        job_npairs = n;
        job_intype = 1'($urandom);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            job_valid = 1'b0;
            vectors += 4;
            if (err_prec !== (want_ep && k == 1)) begin
                miscompares++;
                $display("FAIL bad_job_err_prec k=%0d got=%b want=%b", k, err_prec, want_ep && k == 1);
            end
            if (inst !== 40'h0) begin
                miscompares++;
                $display("FAIL bad_job_inst k=%0d got=%h want=0", k, inst);
            end
            if (comp_en !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_job_comp_en k=%0d got=%b want=0", k, comp_en);
            end
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_job_busy k=%0d got=%b want=0", k, busy);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [39:0] want;
        gen_pairs(2);
        run_job(2'b10, 1'b0, 2, 2, 2, 1'b0, 7);
        reset_bram = 1'b1;
        #1;
        vectors += 5;
        if (inst !== 40'h0)     begin miscompares++; $display("FAIL areset_inst got=%h want=0", inst); end
        if (busy !== 1'b0)      begin miscompares++; $display("FAIL areset_busy got=%b want=0", busy); end
        if (comp_en !== 1'b0)   begin miscompares++; $display("FAIL areset_comp_en got=%b want=0", comp_en); end
        if (job_ready !== 1'b1) begin miscompares++; $display("FAIL areset_job_ready got=%b want=1", job_ready); end
        if (op_ready !== 1'b1)  begin miscompares++; $display("FAIL areset_op_ready got=%b want=1", op_ready); end
        @(negedge clk);
        @(negedge clk);
        reset_bram = 1'b0;
        // The leftover pair must be gone: a one-pair job now waits forever
        job_valid  = 1'b1;
        job_prec   = 2'b01;
        job_intype = 1'b1;
        job_npairs = 8'd1;
        want = 40'h5;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            job_valid = 1'b0;
            vectors += 2;
            if (busy !== 1'b1 || comp_en !== 1'b0) begin
                miscompares++;
                $display("FAIL stuck_wait k=%0d got busy=%b comp_en=%b want busy=1 comp_en=0",
                         k, busy, comp_en);
            end
            if (inst !== want) begin
                miscompares++;
                $display("FAIL stuck_wait_inst k=%0d got=%h want=%h", k, inst, want);
            end
        end
        reset_bram = 1'b1;
        @(negedge clk);
        reset_bram = 1'b0;
    endtask

    initial begin
        reset_bram = 1'b1;
        job_valid  = 1'b0;
        job_prec   = '0;
        job_intype = 1'b0;
        job_npairs = '0;
        op_valid   = 1'b0;
        op_row_1   = '0;
        op_row_2   = '0;
        op_col     = '0;
        op_in_1    = '0;
        op_in_2    = '0;
        test_reset();
        test_prec4_signed();
        test_prec2_single();
        test_random_jobs();
        test_back_to_back();
        test_underrun();
        test_bad_job(2'b00, 8'd1, 1'b1);
        test_bad_job(2'b10, 8'd0, 1'b0);
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
